// File: rtl/frame_buffer_arbiter_if.sv
// frame_buffer_arbiter_if: bundle for two drawing clients and the frame-buffer RAM port.
// Signals: cN_in_* requests, cN_out_* grant/return, mem_* RAM command and read data.
// Modports: slave = arbiter side, master = clients plus RAM side.
interface frame_buffer_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] c0_in_data;
   logic [ADDR_W-1:0] c0_in_addr;
   logic [BE_W-1:0]   c0_in_wben;
   logic              c0_in_op;
   logic              c0_in_rts;
   logic              c0_out_rtr;
   logic [DATA_W-1:0] c0_out_data;
   logic              c0_out_xfc;

   logic [DATA_W-1:0] c1_in_data;
   logic [ADDR_W-1:0] c1_in_addr;
   logic [BE_W-1:0]   c1_in_wben;
   logic              c1_in_op;
   logic              c1_in_rts;
   logic              c1_out_rtr;
   logic [DATA_W-1:0] c1_out_data;
   logic              c1_out_xfc;

   logic              mem_rdy;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_wben;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  c0_in_data, c0_in_addr, c0_in_wben, c0_in_op, c0_in_rts,
      input  c1_in_data, c1_in_addr, c1_in_wben, c1_in_op, c1_in_rts,
      input  mem_rdy, mem_rdata,
      output c0_out_rtr, c0_out_data, c0_out_xfc,
      output c1_out_rtr, c1_out_data, c1_out_xfc,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wben
   );

   modport master (
      output c0_in_data, c0_in_addr, c0_in_wben, c0_in_op, c0_in_rts,
      output c1_in_data, c1_in_addr, c1_in_wben, c1_in_op, c1_in_rts,
      output mem_rdy, mem_rdata,
      input  c0_out_rtr, c0_out_data, c0_out_xfc,
      input  c1_out_rtr, c1_out_data, c1_out_xfc,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wben
   );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: two-client arbiter onto one frame-buffer RAM port.
// Ports: clk, rst_ (async active-low), bus (frame_buffer_arbiter_if.slave).
// One transfer per cycle is registered onto mem_*; reads return on cN_out_data
// with a one-cycle cN_out_xfc strobe RD_LAT+2 cycles after the transfer.
// Option: define C1_PRIORITY_EN to make client 1 win every tie; default is
// round-robin where a tie goes to the client not served last.
module frame_buffer_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_,
   frame_buffer_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   logic              cand0, cand1;
   logic              gnt0, gnt1, xfer;
   logic              last_q, last_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_wben_q, mem_wben_d;
   // Read tags: tv = valid, tc = issuing client; stage RD_LAT lines up with mem_rdata.
   logic [RD_LAT:0]   tv_q, tv_d;
   logic [RD_LAT:0]   tc_q, tc_d;
   logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
   logic              x0_q, x0_d, x1_q, x1_d;

   // last_q = 1 means client 1 was served last, so client 0 wins the next tie.
   always_comb begin
      cand0 = bus.mem_rdy & bus.c0_in_rts;
      cand1 = bus.mem_rdy & bus.c1_in_rts;
`ifdef C1_PRIORITY_EN
      gnt1  = cand1;
      gnt0  = cand0 & ~cand1;
`else
      gnt0  = cand0 & (~cand1 | last_q);
      gnt1  = cand1 & ~gnt0;
`endif
      xfer  = gnt0 | gnt1;
   end

   always_comb begin
      last_d      = last_q;
      mem_en_d    = xfer;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wben_d  = mem_wben_q;
      if (gnt1) begin
         last_d      = 1'b1;
         mem_we_d    = bus.c1_in_op;
         mem_addr_d  = bus.c1_in_addr;
         mem_wdata_d = bus.c1_in_data;
         mem_wben_d  = bus.c1_in_op ? bus.c1_in_wben : '0;
      end else if (gnt0) begin
         last_d      = 1'b0;
         mem_we_d    = bus.c0_in_op;
         mem_addr_d  = bus.c0_in_addr;
         mem_wdata_d = bus.c0_in_data;
         mem_wben_d  = bus.c0_in_op ? bus.c0_in_wben : '0;
      end
   end

   always_comb begin
      tv_d = {tv_q[RD_LAT-1:0], xfer & ~mem_we_d};
      tc_d = {tc_q[RD_LAT-1:0], gnt1};
      x0_d = tv_q[RD_LAT] & ~tc_q[RD_LAT];
      x1_d = tv_q[RD_LAT] &  tc_q[RD_LAT];
      d0_d = x0_d ? bus.mem_rdata : d0_q;
      d1_d = x1_d ? bus.mem_rdata : d1_q;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         last_q      <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wben_q  <= '0;
         tv_q        <= '0;
         tc_q        <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         x0_q        <= 1'b0;
         x1_q        <= 1'b0;
      end else begin
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wben_q  <= mem_wben_d;
         tv_q        <= tv_d;
         tc_q        <= tc_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
      end
   end

   assign bus.c0_out_rtr  = gnt0;
   assign bus.c1_out_rtr  = gnt1;
   assign bus.c0_out_data = d0_q;
   assign bus.c1_out_data = d1_q;
   assign bus.c0_out_xfc  = x0_q;
   assign bus.c1_out_xfc  = x1_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_wben    = mem_wben_q;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector bench for frame_buffer_arbiter.
// Two DUTs: RD_LAT=1 for arbitration/return, RD_LAT=3 for latency and mid-read reset.
module tb_frame_buffer_arbiter;
   logic clk = 1'b0;
   logic rst_ = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   frame_buffer_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
   frame_buffer_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b3 ();

   frame_buffer_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) u_dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (b1.slave)
   );

   frame_buffer_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) u_dut3 (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (b3.slave)
   );

   // RAM models: contents start as 0xA500_0000 | addr[7:0].
   logic [31:0] ram1 [256];
   logic [31:0] ram3 [256];
   logic [31:0] p1;
   logic [31:0] p3 [3];

   assign b1.mem_rdata = p1;
   assign b3.mem_rdata = p3[2];

   always @(posedge clk) begin
      if (!rst_) begin
         for (int i = 0; i < 256; i++) begin
            ram1[i] <= 32'hA500_0000 | 32'(i);
            ram3[i] <= 32'hA500_0000 | 32'(i);
         end
         p1 <= '0;
         for (int i = 0; i < 3; i++) p3[i] <= '0;
      end else begin
         if (b1.mem_en && b1.mem_we)
            for (int b = 0; b < 4; b++)
               if (b1.mem_wben[b])
                  ram1[b1.mem_addr[7:0]][8*b +: 8] <= b1.mem_wdata[8*b +: 8];
         if (b1.mem_en && !b1.mem_we) p1 <= ram1[b1.mem_addr[7:0]];
         if (b3.mem_en && b3.mem_we)
            for (int b = 0; b < 4; b++)
               if (b3.mem_wben[b])
                  ram3[b3.mem_addr[7:0]][8*b +: 8] <= b3.mem_wdata[8*b +: 8];
         p3[0] <= (b3.mem_en && !b3.mem_we) ? ram3[b3.mem_addr[7:0]] : 32'h0;
         p3[1] <= p3[0];
         p3[2] <= p3[1];
      end
   end

   typedef struct {
      logic        r0;
      logic        op0;
      logic [15:0] a0;
      logic        r1;
      logic        op1;
      logic [15:0] a1;
      logic        rdy;
      logic        e0;
      logic        e1;
      logic        en;
      logic        we;
      logic [15:0] ea;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r0, op0, input logic [15:0] a0,
                               input logic r1, op1, input logic [15:0] a1,
                               input logic rdy, e0, e1, en, we,
                               input logic [15:0] ea);
      vec_t v;
      v.r0 = r0; v.op0 = op0; v.a0 = a0;
      v.r1 = r1; v.op1 = op1; v.a1 = a1;
      v.rdy = rdy; v.e0 = e0; v.e1 = e1;
      v.en = en; v.we = we; v.ea = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r0, op0, input logic [15:0] a0,
                      input logic [31:0] d0, input logic [3:0] w0,
                      input logic r1, op1, input logic [15:0] a1,
                      input logic [31:0] d1, input logic [3:0] w1);
      b1.c0_in_rts = r0; b1.c0_in_op = op0; b1.c0_in_addr = a0;
      b1.c0_in_data = d0; b1.c0_in_wben = w0;
      b1.c1_in_rts = r1; b1.c1_in_op = op1; b1.c1_in_addr = a1;
      b1.c1_in_data = d1; b1.c1_in_wben = w1;
   endtask

   task automatic idle1();
      drv(0, 0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
   endtask

   task automatic drv3(input logic r1, op1, input logic [15:0] a1);
      b3.c1_in_rts = r1; b3.c1_in_op = op1; b3.c1_in_addr = a1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      int          lat;
      int          n;
      int          other;
      logic [31:0] dat;
      logic [31:0] got [4];

      idle1();
      b1.mem_rdy = 1'b1;
      b3.c0_in_rts = 0; b3.c0_in_op = 0; b3.c0_in_addr = '0;
      b3.c0_in_data = '0; b3.c0_in_wben = '0;
      b3.c1_in_data = '0; b3.c1_in_wben = '0;
      drv3(0, 0, 16'h0);
      b3.mem_rdy = 1'b1;

      // Tie sequence first so the reset pointer decides the first winner.
      for (int k = 0; k < 6; k++) begin
`ifdef C1_PRIORITY_EN
         tbl.push_back(mk(1, 1, 16'h0100, 1, 1, 16'h0200, 1, 0, 1, 1, 1, 16'h0200));
`else
         if (k % 2 == 0)
            tbl.push_back(mk(1, 1, 16'h0100, 1, 1, 16'h0200, 1, 1, 0, 1, 1, 16'h0100));
         else
            tbl.push_back(mk(1, 1, 16'h0100, 1, 1, 16'h0200, 1, 0, 1, 1, 1, 16'h0200));
`endif
      end
      tbl.push_back(mk(1, 1, 16'h0100, 0, 0, 16'h0, 1, 1, 0, 1, 1, 16'h0100));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1, 0, 16'h0100, 0, 0, 16'h0, 0, 0, 0, 0, 0, 16'h0));
      tbl.push_back(mk(1, 0, 16'h0100, 0, 0, 16'h0, 1, 1, 0, 1, 0, 16'h0100));
      tbl.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0200, 1, 0, 1, 1, 0, 16'h0200));
      tbl.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0));
`ifdef C1_PRIORITY_EN
      tbl.push_back(mk(1, 0, 16'h0100, 1, 0, 16'h0200, 1, 0, 1, 1, 0, 16'h0200));
      tbl.push_back(mk(1, 0, 16'h0100, 1, 0, 16'h0200, 1, 0, 1, 1, 0, 16'h0200));
`else
      tbl.push_back(mk(1, 0, 16'h0100, 1, 0, 16'h0200, 1, 1, 0, 1, 0, 16'h0100));
      tbl.push_back(mk(1, 0, 16'h0100, 1, 0, 16'h0200, 1, 0, 1, 1, 0, 16'h0200));
`endif
      tbl.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 16'h0));

      // Reset state.
      repeat (3) tick();
      chk("rst_mem_en", b1.mem_en, 0);
      chk("rst_mem_we", b1.mem_we, 0);
      chk("rst_mem_addr", b1.mem_addr, 0);
      chk("rst_mem_wdata", b1.mem_wdata, 0);
      chk("rst_mem_wben", b1.mem_wben, 0);
      chk("rst_c0_data", b1.c0_out_data, 0);
      chk("rst_c1_data", b1.c1_out_data, 0);
      chk("rst_xfc", {b1.c0_out_xfc, b1.c1_out_xfc}, 0);
      chk("rst_rtr", {b1.c0_out_rtr, b1.c1_out_rtr}, 0);
      rst_ = 1'b1;

      // Table: grant decision, then the registered RAM command.
      foreach (tbl[i]) begin
         v = tbl[i];
         b1.mem_rdy = v.rdy;
         drv(v.r0, v.op0, v.a0, {16'hC0C0, v.a0}, 4'hF,
             v.r1, v.op1, v.a1, {16'hC1C1, v.a1}, 4'hF);
         @(negedge clk);
         chk($sformatf("v%0d_rtr0", i), b1.c0_out_rtr, v.e0);
         chk($sformatf("v%0d_rtr1", i), b1.c1_out_rtr, v.e1);
         chk($sformatf("v%0d_rtr_both", i), b1.c0_out_rtr & b1.c1_out_rtr, 0);
         tick();
         chk($sformatf("v%0d_mem_en", i), b1.mem_en, v.en);
         if (v.en) begin
            chk($sformatf("v%0d_mem_we", i), b1.mem_we, v.we);
            chk($sformatf("v%0d_mem_addr", i), b1.mem_addr, v.ea);
         end
      end
      idle1();
      b1.mem_rdy = 1'b1;
      repeat (6) tick();

      // Full-word write from client 0: one command, no return strobe.
      drv(1, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 16'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("wr_rtr0", b1.c0_out_rtr, 1);
      tick();
      idle1();
      chk("wr_mem_en", b1.mem_en, 1);
      chk("wr_mem_we", b1.mem_we, 1);
      chk("wr_mem_addr", b1.mem_addr, 16'h0010);
      chk("wr_mem_wdata", b1.mem_wdata, 32'hDEADBEEF);
      chk("wr_mem_wben", b1.mem_wben, 4'hF);
      n = 0;
      repeat (4) begin
         tick();
         if (b1.mem_en) n++;
         if (b1.c0_out_xfc || b1.c1_out_xfc) n += 10;
      end
      chk("wr_single_no_xfc", n, 0);

      // Read back from client 0: strobe exactly 3 cycles after transfer.
      drv(1, 0, 16'h0010, 32'h0, 4'hF, 0, 0, 16'h0, 32'h0, 4'h0);
      tick();
      idle1();
      chk("rd_mem_en", b1.mem_en, 1);
      chk("rd_mem_we", b1.mem_we, 0);
      chk("rd_mem_wben", b1.mem_wben, 0);
      lat = 0; n = 0; other = 0; dat = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         if (b1.c1_out_xfc) other++;
         if (b1.c0_out_xfc) begin
            n++;
            if (lat == 0) begin
               lat = k;
               dat = b1.c0_out_data;
            end
         end
      end
      chk("rd_latency", lat, 3);
      chk("rd_data", dat, 32'hDEADBEEF);
      chk("rd_xfc_count", n, 1);
      chk("rd_c1_no_xfc", other, 0);
      chk("rd_data_hold", b1.c0_out_data, 32'hDEADBEEF);

      // Partial write then immediate read of the same word by client 1.
      drv(0, 0, 16'h0, 32'h0, 4'h0, 1, 1, 16'h0020, 32'hAABBCCDD, 4'b0011);
      tick();
      chk("pw_mem_wben", b1.mem_wben, 4'b0011);
      drv(0, 0, 16'h0, 32'h0, 4'h0, 1, 0, 16'h0020, 32'h0, 4'hF);
      tick();
      idle1();
      lat = 0; other = 0; dat = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick();
         if (b1.c0_out_xfc) other++;
         if (b1.c1_out_xfc && lat == 0) begin
            lat = k;
            dat = b1.c1_out_data;
         end
      end
      chk("pw_c1_latency", lat, 3);
      chk("pw_c1_data", dat, 32'hA500CCDD);
      chk("pw_c0_no_xfc", other, 0);

      // Back-to-back reads return on consecutive cycles in issue order.
      drv(1, 0, 16'h0010, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
      tick();
      drv(1, 0, 16'h0020, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
      tick();
      idle1();
      lat = 0; n = 0;
      for (int k = 2; k <= 9; k++) begin
         if (k > 2) tick();
         if (b1.c0_out_xfc) begin
            if (lat == 0) lat = k;
            if (n < 4) got[n] = b1.c0_out_data;
            n++;
         end
      end
      chk("b2b_first_lat", lat, 3);
      chk("b2b_count", n, 2);
      chk("b2b_data0", got[0], 32'hDEADBEEF);
      chk("b2b_data1", got[1], 32'hA500CCDD);

      // RD_LAT=3: latency RD_LAT+2, then reset while a read is in flight.
      drv3(1, 0, 16'h0030);
      tick();
      drv3(0, 0, 16'h0);
      lat = 0; dat = '0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) tick();
         if (b3.c1_out_xfc && lat == 0) begin
            lat = k;
            dat = b3.c1_out_data;
         end
      end
      chk("l3_latency", lat, 5);
      chk("l3_data", dat, 32'hA5000030);

      drv3(1, 0, 16'h0040);
      tick();
      drv3(0, 0, 16'h0);
      tick();
      rst_ = 1'b0;
      #1;
      chk("mrst_mem_en", b3.mem_en, 0);
      chk("mrst_mem_addr", b3.mem_addr, 0);
      chk("mrst_c1_data", b3.c1_out_data, 0);
      tick();
      rst_ = 1'b1;
      n = 0;
      repeat (10) begin
         tick();
         if (b3.c0_out_xfc || b3.c1_out_xfc) n++;
      end
      chk("mrst_no_xfc", n, 0);
      chk("mrst_c1_data_after", b3.c1_out_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
